// File: rtl/mem_arbiter_if.sv
// Bus bundle for mem_arbiter: the cpu and ldr request ports, the memory side and busy.
// slave = the arbiter's view; master = the requesters and the memory model.
interface mem_arbiter_if #(
    parameter int AW = 8,
    parameter int DW = 8
);
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_gnt;
    logic          cpu_done;
    logic [DW-1:0] cpu_rdata;

    logic          ldr_req;
    logic          ldr_we;
    logic [AW-1:0] ldr_addr;
    logic [DW-1:0] ldr_wdata;
    logic          ldr_gnt;
    logic          ldr_done;
    logic [DW-1:0] ldr_rdata;

    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_read;
    logic          mem_write;
    logic [DW-1:0] mem_rdata;

    logic          busy;

    // Handshake: a requester holds req/we/addr/wdata steady until its gnt pulse;
    // gnt means the inputs were latched, done marks completion one or more cycles later.
    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_gnt, cpu_done, cpu_rdata,
        input  ldr_req, ldr_we, ldr_addr, ldr_wdata,
        output ldr_gnt, ldr_done, ldr_rdata,
        output mem_addr, mem_wdata, mem_read, mem_write,
        input  mem_rdata,
        output busy
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_gnt, cpu_done, cpu_rdata,
        output ldr_req, ldr_we, ldr_addr, ldr_wdata,
        input  ldr_gnt, ldr_done, ldr_rdata,
        input  mem_addr, mem_wdata, mem_read, mem_write,
        output mem_rdata,
        input  busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port (cpu / ldr) arbiter for the single-ported TinyMIPS memory: IDLE -> ISSUE -> [WAIT] -> DONE.
// Define MEMARB_CPU_PRIO_EN for fixed cpu priority; otherwise ties are settled round-robin.
module mem_arbiter #(
    parameter int AW      = 8,
    parameter int DW      = 8,
    parameter int MEM_LAT = 1
) (
    input  logic        clk,
    input  logic        reset,
    mem_arbiter_if.slave bus,
    output logic [1:0]  state_o
);
    localparam int CW = $clog2(MEM_LAT + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_e;

    state_e        state_q;
    logic          owner_q;     // 0 = cpu, 1 = ldr
    logic          we_q;
    logic [CW-1:0] cnt_q;
    logic          cpu_gnt_q, ldr_gnt_q;
    logic          cpu_done_q, ldr_done_q;
    logic [DW-1:0] cpu_rdata_q, ldr_rdata_q;
    logic [AW-1:0] mem_addr_q;
    logic [DW-1:0] mem_wdata_q;
    logic          mem_read_q, mem_write_q;
    logic          busy_q;
    logic          pick_ldr;
    logic          pick_we;

`ifndef MEMARB_CPU_PRIO_EN
    logic          rr_q;        // 1 = ldr wins the next tie
`endif

    always_comb begin
`ifdef MEMARB_CPU_PRIO_EN
        pick_ldr = !bus.cpu_req;
`else
        pick_ldr = bus.ldr_req && (!bus.cpu_req || rr_q);
`endif
        pick_we = pick_ldr ? bus.ldr_we : bus.cpu_we;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            owner_q     <= 1'b0;
            we_q        <= 1'b0;
            cnt_q       <= '0;
            cpu_gnt_q   <= 1'b0;
            ldr_gnt_q   <= 1'b0;
            cpu_done_q  <= 1'b0;
            ldr_done_q  <= 1'b0;
            cpu_rdata_q <= '0;
            ldr_rdata_q <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            busy_q      <= 1'b0;
`ifndef MEMARB_CPU_PRIO_EN
            rr_q        <= 1'b0;
`endif
        end else begin
            // Pulses and the memory bus default low; each state re-asserts what it owns.
            cpu_gnt_q   <= 1'b0;
            ldr_gnt_q   <= 1'b0;
            cpu_done_q  <= 1'b0;
            ldr_done_q  <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            case (state_q)
                IDLE: begin
                    if (bus.cpu_req || bus.ldr_req) begin
                        owner_q     <= pick_ldr;
                        we_q        <= pick_we;
                        mem_addr_q  <= pick_ldr ? bus.ldr_addr : bus.cpu_addr;
                        mem_wdata_q <= pick_ldr ? bus.ldr_wdata : bus.cpu_wdata;
                        mem_write_q <= pick_we;
                        mem_read_q  <= !pick_we;
                        cpu_gnt_q   <= !pick_ldr;
                        ldr_gnt_q   <= pick_ldr;
                        busy_q      <= 1'b1;
                        state_q     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (we_q) begin
                        cpu_done_q <= !owner_q;
                        ldr_done_q <= owner_q;
                        state_q    <= DONE;
                    end else begin
                        cnt_q   <= CW'(MEM_LAT);
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        if (owner_q) ldr_rdata_q <= bus.mem_rdata;
                        else         cpu_rdata_q <= bus.mem_rdata;
                        cpu_done_q <= !owner_q;
                        ldr_done_q <= owner_q;
                        state_q    <= DONE;
                    end
                end
                DONE: begin
`ifndef MEMARB_CPU_PRIO_EN
                    rr_q    <= !owner_q;
`endif
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.cpu_gnt   = cpu_gnt_q;
    assign bus.ldr_gnt   = ldr_gnt_q;
    assign bus.cpu_done  = cpu_done_q;
    assign bus.ldr_done  = ldr_done_q;
    assign bus.cpu_rdata = cpu_rdata_q;
    assign bus.ldr_rdata = ldr_rdata_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_read  = mem_read_q;
    assign bus.mem_write = mem_write_q;
    assign bus.busy      = busy_q;
    assign state_o       = state_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter (MEM_LAT=3): directed timing checks plus an rdata scoreboard.
// Build with MEMARB_CPU_PRIO_EN defined to check the fixed-priority variant.
module tb_mem_arbiter;
    localparam int LAT = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] state;

    mem_arbiter_if #(.AW(8), .DW(8)) bus();

    mem_arbiter #(.AW(8), .DW(8), .MEM_LAT(LAT)) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .state_o (state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] init_val(input logic [7:0] a);
        return (a == 8'h10) ? 8'hA5 : (a * 8'd37 + 8'd11);
    endfunction

    // Memory model: data valid exactly LAT cycles after the read strobe, inverted junk otherwise.
    logic [7:0] mem_arr [256];
    bit         written [256];
    logic [7:0] rd_addr = 8'h00;
    int         rd_age  = 0;

    always @(posedge clk) begin
        if (bus.mem_write) begin
            mem_arr[bus.mem_addr] <= bus.mem_wdata;
            written[bus.mem_addr] <= 1'b1;
        end
        if (bus.mem_read) begin
            rd_addr <= bus.mem_addr;
            rd_age  <= 1;
        end else if (rd_age != 0 && rd_age < LAT + 2) begin
            rd_age <= rd_age + 1;
        end
    end

    always @(negedge clk) begin
        logic [7:0] v;
        v = written[rd_addr] ? mem_arr[rd_addr] : init_val(rd_addr);
        bus.mem_rdata = (rd_age == LAT) ? v : ~v;
    end

    // Scoreboard: expected rdata per port pushed at stimulus, popped at done.
    logic [7:0] cpu_exp_q[$];
    logic [7:0] ldr_exp_q[$];
    logic [7:0] sh_mem [256];
    logic [7:0] cpu_model, ldr_model;
    logic [7:0] cpu_seen, ldr_seen;
    int         cpu_done_cnt = 0;
    int         ldr_done_cnt = 0;
    int         gnt_log[$];

    always @(negedge clk) begin
        logic [7:0] e;
        if (reset) begin
            cpu_exp_q.delete();
            ldr_exp_q.delete();
            cpu_seen = 8'h00;
            ldr_seen = 8'h00;
        end else begin
            if (bus.cpu_gnt) gnt_log.push_back(0);
            if (bus.ldr_gnt) gnt_log.push_back(1);
            if (bus.cpu_done) begin
                cpu_done_cnt++;
                check("cpu_done_expected", 32'(cpu_exp_q.size() != 0), 1);
                if (cpu_exp_q.size() != 0) begin
                    e = cpu_exp_q.pop_front();
                    check("cpu_rdata", bus.cpu_rdata, e);
                    cpu_seen = e;
                end
                check("ldr_rdata_hold", bus.ldr_rdata, ldr_seen);
            end
            if (bus.ldr_done) begin
                ldr_done_cnt++;
                check("ldr_done_expected", 32'(ldr_exp_q.size() != 0), 1);
                if (ldr_exp_q.size() != 0) begin
                    e = ldr_exp_q.pop_front();
                    check("ldr_rdata", bus.ldr_rdata, e);
                    ldr_seen = e;
                end
                check("cpu_rdata_hold", bus.cpu_rdata, cpu_seen);
            end
            if (!bus.mem_read && !bus.mem_write)
                check("bus_zero_outside_issue", {bus.mem_addr, bus.mem_wdata}, 0);
        end
    end

    function automatic logic [7:0] push_exp(input bit port, input bit we,
                                            input logic [7:0] addr, input logic [7:0] wdata);
        logic [7:0] e;
        if (we) begin
            sh_mem[addr] = wdata;
            e = port ? ldr_model : cpu_model;
        end else begin
            e = sh_mem[addr];
            if (port) ldr_model = e;
            else      cpu_model = e;
        end
        if (port) ldr_exp_q.push_back(e);
        else      cpu_exp_q.push_back(e);
        return e;
    endfunction

    task automatic drive_req(input bit port, input bit req, input bit we,
                             input logic [7:0] addr, input logic [7:0] wdata);
        if (port) begin
            bus.ldr_req = req; bus.ldr_we = we; bus.ldr_addr = addr; bus.ldr_wdata = wdata;
        end else begin
            bus.cpu_req = req; bus.cpu_we = we; bus.cpu_addr = addr; bus.cpu_wdata = wdata;
        end
    endtask

    // One transaction with the other port idle; checks every cycle up to the IDLE after DONE.
    task automatic run_txn(input bit port, input bit we, input logic [7:0] addr, input logic [7:0] wdata);
        int total;
        logic [7:0] e;
        total = we ? 2 : LAT + 2;
        @(negedge clk);
        e = push_exp(port, we, addr, wdata);
        drive_req(port, 1'b1, we, addr, wdata);
        for (int k = 1; k <= total + 1; k++) begin
            @(negedge clk);
            check("gnt", port ? bus.ldr_gnt : bus.cpu_gnt, 32'(k == 1));
            check("other_gnt", port ? bus.cpu_gnt : bus.ldr_gnt, 0);
            check("mem_read", bus.mem_read, 32'(!we && k == 1));
            check("mem_write", bus.mem_write, 32'(we && k == 1));
            check("done", port ? bus.ldr_done : bus.cpu_done, 32'(k == total));
            check("other_done", port ? bus.cpu_done : bus.ldr_done, 0);
            check("busy", bus.busy, 32'(k <= total));
            if (k == 1) begin
                check("mem_addr", bus.mem_addr, addr);
                check("mem_wdata", bus.mem_wdata, wdata);
                drive_req(port, 1'b0, 1'b0, 8'($urandom), 8'($urandom));
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int guard;
        int k;
        int d0;
        int exp_order[4];

        for (int i = 0; i < 256; i++) sh_mem[i] = init_val(8'(i));
        cpu_model = 8'h00;
        ldr_model = 8'h00;
        drive_req(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        drive_req(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Reset state
        check("rst_state", state, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_strobes", {bus.mem_read, bus.mem_write, bus.cpu_gnt, bus.ldr_gnt, bus.cpu_done, bus.ldr_done}, 0);
        check("rst_rdata", {bus.cpu_rdata, bus.ldr_rdata}, 0);
        check("rst_bus", {bus.mem_addr, bus.mem_wdata}, 0);

        // cpu read of 0x10 (A5), then ldr write 0x3F=5A, read back through cpu
        run_txn(1'b0, 1'b0, 8'h10, 8'h00);
        check("ldr_rdata_untouched", bus.ldr_rdata, 0);
        run_txn(1'b1, 1'b1, 8'h3F, 8'h5A);
        run_txn(1'b0, 1'b0, 8'h3F, 8'h00);

        // Random single-port traffic
        for (int i = 0; i < 10; i++)
            run_txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    8'($urandom_range(0, 63)), 8'($urandom));
        run_txn(1'b1, 1'b0, 8'h21, 8'h00);   // last owner ldr: next tie goes to cpu

        // Continuous contention, two reads per port
        gnt_log.delete();
        fork
            begin
                int n = 0;
                int g = 0;
                @(negedge clk);
                drive_req(1'b0, 1'b1, 1'b0, 8'h20, 8'h00);
                void'(push_exp(1'b0, 1'b0, 8'h20, 8'h00));
                while (n < 2 && g < 200) begin
                    @(negedge clk);
                    g++;
                    if (bus.cpu_gnt) begin
                        n++;
                        if (n < 2) void'(push_exp(1'b0, 1'b0, 8'h20, 8'h00));
                        else       drive_req(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
                    end
                end
                check("cpu_grant_count", n, 2);
            end
            begin
                int n = 0;
                int g = 0;
                @(negedge clk);
                drive_req(1'b1, 1'b1, 1'b0, 8'h30, 8'h00);
                void'(push_exp(1'b1, 1'b0, 8'h30, 8'h00));
                while (n < 2 && g < 200) begin
                    @(negedge clk);
                    g++;
                    if (bus.ldr_gnt) begin
                        n++;
                        if (n < 2) void'(push_exp(1'b1, 1'b0, 8'h30, 8'h00));
                        else       drive_req(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
                    end
                end
                check("ldr_grant_count", n, 2);
            end
        join
        guard = 0;
        while ((bus.busy || cpu_exp_q.size() != 0 || ldr_exp_q.size() != 0) && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        check("contention_drain", 32'(guard < 40), 1);
`ifdef MEMARB_CPU_PRIO_EN
        exp_order = '{0, 0, 1, 1};
`else
        exp_order = '{0, 1, 0, 1};
`endif
        check("grant_log_size", gnt_log.size(), 4);
        for (int i = 0; i < 4 && i < gnt_log.size(); i++)
            check("grant_order", gnt_log[i], exp_order[i]);

        // ldr request raised during cpu WAIT must wait for cpu DONE plus one IDLE cycle
        @(negedge clk);
        void'(push_exp(1'b0, 1'b0, 8'h44, 8'h00));
        drive_req(1'b0, 1'b1, 1'b0, 8'h44, 8'h00);
        @(negedge clk);
        check("blk_cpu_gnt", bus.cpu_gnt, 1);
        drive_req(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        @(negedge clk);
        void'(push_exp(1'b1, 1'b0, 8'h55, 8'h00));
        drive_req(1'b1, 1'b1, 1'b0, 8'h55, 8'h00);
        k = 2;
        while (!bus.cpu_done && k < 20) begin
            check("ldr_gnt_blocked", bus.ldr_gnt, 0);
            @(negedge clk);
            k++;
        end
        check("blk_cpu_done_lat", k, LAT + 2);
        check("blk_ldr_gnt_in_done", bus.ldr_gnt, 0);
        @(negedge clk);
        check("blk_ldr_gnt_in_idle", bus.ldr_gnt, 0);
        check("blk_idle_busy", bus.busy, 0);
        @(negedge clk);
        check("blk_ldr_gnt", bus.ldr_gnt, 1);
        drive_req(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
        guard = 0;
        while (!bus.ldr_done && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check("blk_ldr_done_seen", 32'(bus.ldr_done), 1);
        @(negedge clk);

        // Reset during the WAIT of a ldr read aborts it
        @(negedge clk);
        void'(push_exp(1'b1, 1'b0, 8'h66, 8'h00));
        drive_req(1'b1, 1'b1, 1'b0, 8'h66, 8'h00);
        @(negedge clk);
        check("abort_ldr_gnt", bus.ldr_gnt, 1);
        drive_req(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
        @(negedge clk);
        check("abort_in_wait", state, 2);
        d0 = ldr_done_cnt;
        reset = 1'b1;
        cpu_model = 8'h00;
        ldr_model = 8'h00;
        @(negedge clk);
        check("abort_state", state, 0);
        check("abort_pulses", {bus.mem_read, bus.mem_write, bus.cpu_gnt, bus.ldr_gnt, bus.cpu_done, bus.ldr_done}, 0);
        check("abort_busy", bus.busy, 0);
        check("abort_ldr_rdata", bus.ldr_rdata, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (LAT + 4) @(negedge clk);
        check("abort_no_ldr_done", ldr_done_cnt, d0);
        run_txn(1'b0, 1'b0, 8'h10, 8'h00);
        run_txn(1'b1, 1'b1, 8'h12, 8'hC3);
        run_txn(1'b1, 1'b0, 8'h12, 8'h00);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
